// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit: load-use stall, muldiv freeze, branch flush, EX operand forwarding; stall_cycles with PIPE_HAZARD_STALL_CNT_EN.
// Latency: outputs combinational from inputs and a registered EX/MEM/WB shadow pipeline; state updates each clk edge.
// Backpressure: freeze holds PC, IF/ID and ID/EX; load-use holds PC and IF/ID and inserts a bubble into ID/EX.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW        = 5,
   parameter int unsigned MULDIV_CYCLES = 4,
   parameter int unsigned CNT_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_muldiv,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_branch_taken,
   output logic              pc_write_enable,
   output logic              enable_ifid,
   output logic              enable_idex,
   output logic              nop_mux_sel,
   output logic              flush_ifid,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
`ifdef PIPE_HAZARD_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles
`endif
);

   if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 255 || CNT_W < 1) begin : g_param_check
      $error("pipe_hazard_ctrl: MULDIV_CYCLES must be 1..255 and CNT_W >= 1");
   end

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic              muldiv;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } stage_t;

   stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   stage_t     id_s;
   logic [7:0] busy_q, busy_d;
   logic       freeze, load_use_raw, load_use, flush;

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input stage_t mem_s, input stage_t wb_s);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_s.valid && mem_s.regwrite && mem_s.rd != '0 && mem_s.rd == src)
         sel = 2'b01;
      else if (wb_s.valid && wb_s.regwrite && wb_s.rd != '0 && wb_s.rd == src)
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      id_s = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread,
               muldiv: id_muldiv, rd: id_rd, rs: id_rs, rt: id_rt};

      freeze       = (busy_q != 8'd0);
      load_use_raw = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                     ((id_uses_rs && ex_q.rd == id_rs) || (id_uses_rt && ex_q.rd == id_rt));
      flush        = ex_branch_taken && !freeze;
      load_use     = load_use_raw && !flush && !freeze;

      pc_write_enable = !(freeze || load_use);
      enable_ifid     = !(freeze || load_use);
      enable_idex     = !freeze;
      nop_mux_sel     = flush || load_use;
      flush_ifid      = flush;

      fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);

      // A frozen long op stays in EX while MEM takes bubbles, so older results still retire.
      wb_d   = mem_q;
      ex_d   = ex_q;
      mem_d  = '0;
      busy_d = (busy_q != 8'd0) ? busy_q - 8'd1 : 8'd0;
      if (!freeze) begin
         mem_d = ex_q;
         ex_d  = (flush || load_use) ? stage_t'('0) : id_s;
         if (ex_d.valid && ex_d.muldiv)
            busy_d = 8'(MULDIV_CYCLES - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
         busy_q <= 8'd0;
      end else begin
         ex_q   <= ex_d;
         mem_q  <= mem_d;
         wb_q   <= wb_d;
         busy_q <= busy_d;
      end
   end

`ifdef PIPE_HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (!pc_write_enable && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

   // WB only needs valid/regwrite/rd; the remaining fields ride along for a uniform stage record.
   logic unused_wb_fields;
   assign unused_wb_fields = ^{wb_q.memread, wb_q.muldiv, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against an instruction-level model.
module tb_pipe_hazard_ctrl;
   localparam int AW = 5;
   localparam int MC = 4;
   localparam int CW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          id_valid, id_regwrite, id_memread, id_muldiv;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          id_uses_rs, id_uses_rt, ex_branch_taken;
   logic          pc_write_enable, enable_ifid, enable_idex, nop_mux_sel, flush_ifid;
   logic [1:0]    fwd_a, fwd_b;
`ifdef PIPE_HAZARD_STALL_CNT_EN
   logic [CW-1:0] stall_cycles;
`endif

   wire [8:0] obs = {pc_write_enable, enable_ifid, enable_idex, nop_mux_sel, flush_ifid, fwd_a, fwd_b};

   int errors = 0;
   int checks = 0;
   logic [8:0] exp;

   pipe_hazard_ctrl #(.REG_AW(AW), .MULDIV_CYCLES(MC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_muldiv(id_muldiv),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_branch_taken(ex_branch_taken),
      .pc_write_enable(pc_write_enable), .enable_ifid(enable_ifid), .enable_idex(enable_idex),
      .nop_mux_sel(nop_mux_sel), .flush_ifid(flush_ifid),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef PIPE_HAZARD_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   task automatic set_id(input bit v, input bit w, input bit ld, input bit md,
                         input int rs, input int rt, input int rd, input bit urs, input bit urt);
      id_valid = v; id_regwrite = w; id_memread = ld; id_muldiv = md;
      id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
      id_uses_rs = urs; id_uses_rt = urt;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ex_branch_taken = 1'b0;
      idle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      exp = 9'b111_0_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, exp); end
`ifdef PIPE_HAZARD_STALL_CNT_EN
      checks++;
      if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles); end
`endif
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1, 1, 1, 0, 1, 2, 8, 1, 0);          // lw r8
      tick();
      set_id(1, 1, 0, 0, 8, 3, 10, 1, 1);         // add r10 = r8 + r3
      #1;
      exp = 9'b001_1_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_use_stall: got %b want %b", obs, exp); end
      tick();
      #1;
      exp = 9'b111_0_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_use_release: got %b want %b", obs, exp); end
      tick();
      idle();
      #1;
      exp = 9'b111_0_0_10_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_use_fwd_wb: got %b want %b", obs, exp); end
   endtask

   task automatic test_forwarding();
      // back-to-back: MEM forward
      do_reset();
      set_id(1, 1, 0, 0, 1, 2, 9, 1, 1);
      tick();
      set_id(1, 1, 0, 0, 9, 9, 11, 1, 1);
      tick();
      idle();
      #1;
      exp = 9'b111_0_0_01_01;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fwd_mem: got %b want %b", obs, exp); end
      // one independent instruction between: WB forward
      do_reset();
      set_id(1, 1, 0, 0, 1, 2, 9, 1, 1);
      tick();
      set_id(1, 1, 0, 0, 3, 4, 12, 1, 1);
      tick();
      set_id(1, 1, 0, 0, 9, 9, 11, 1, 1);
      tick();
      idle();
      #1;
      exp = 9'b111_0_0_10_10;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fwd_wb: got %b want %b", obs, exp); end
      // both MEM and WB write r9: MEM wins
      do_reset();
      set_id(1, 1, 0, 0, 1, 2, 9, 1, 1);
      tick();
      set_id(1, 1, 0, 0, 5, 6, 9, 1, 1);
      tick();
      set_id(1, 1, 0, 0, 9, 9, 11, 1, 1);
      tick();
      idle();
      #1;
      exp = 9'b111_0_0_01_01;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fwd_mem_priority: got %b want %b", obs, exp); end
   endtask

   task automatic test_r0();
      do_reset();
      set_id(1, 1, 1, 0, 1, 2, 0, 1, 0);          // load into r0
      tick();
      set_id(1, 1, 0, 0, 0, 0, 3, 1, 1);          // reader of r0
      #1;
      exp = 9'b111_0_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL r0_no_stall: got %b want %b", obs, exp); end
      tick();
      idle();
      #1;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL r0_no_fwd: got %b want %b", obs, exp); end
   endtask

   task automatic test_muldiv();
      int s0;
      do_reset();
      set_id(1, 1, 0, 1, 0, 0, 5, 0, 0);
      tick();
      idle();
      s0 = 0;
`ifdef PIPE_HAZARD_STALL_CNT_EN
      #1;
      s0 = int'(stall_cycles);
`endif
      for (int i = 0; i < MC - 1; i++) begin
         #1;
         exp = 9'b000_0_0_00_00;
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL muldiv_frozen_%0d: got %b want %b", i, obs, exp); end
         tick();
      end
      #1;
      exp = 9'b111_0_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL muldiv_release: got %b want %b", obs, exp); end
`ifdef PIPE_HAZARD_STALL_CNT_EN
      checks++;
      if (int'(stall_cycles) !== s0 + MC - 1) begin
         errors++; $display("FAIL muldiv_stall_cnt: got %0d want %0d", stall_cycles, s0 + MC - 1);
      end
`endif
   endtask

   task automatic test_branch_load_use();
      do_reset();
      set_id(1, 1, 1, 0, 1, 2, 8, 1, 0);
      tick();
      set_id(1, 1, 0, 0, 8, 3, 10, 1, 1);
      ex_branch_taken = 1'b1;
      #1;
      exp = 9'b111_1_1_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL branch_over_load_use: got %b want %b", obs, exp); end
      ex_branch_taken = 1'b0;
   endtask

   task automatic test_reset_mid_freeze();
      do_reset();
      set_id(1, 1, 0, 0, 1, 2, 7, 1, 1);
      tick();
      set_id(1, 1, 0, 1, 7, 0, 6, 1, 0);          // muldiv reading r7
      tick();
      idle();
      #1;
      exp = 9'b000_0_0_01_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL freeze1_fwd_mem: got %b want %b", obs, exp); end
      tick();
      #1;
      exp = 9'b000_0_0_10_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL freeze2_fwd_wb: got %b want %b", obs, exp); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      exp = 9'b111_0_0_00_00;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_abort_freeze: got %b want %b", obs, exp); end
      tick();
      #1;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_abort_stays: got %b want %b", obs, exp); end
   endtask

   // Instruction-level model: each stage holds an instruction record; a long op blocks EX for MC cycles.
   typedef struct {
      bit v, w, ld, md;
      int rd, rs, rt;
   } ins_t;

   ins_t   m_ex, m_mem, m_wb;
   int     m_ex_left;
   longint m_stalls;

   function automatic ins_t bubble();
      ins_t b;
      b = '{v: 0, w: 0, ld: 0, md: 0, rd: 0, rs: 0, rt: 0};
      return b;
   endfunction

   function automatic logic [1:0] m_fwd(int r);
      if (m_mem.v && m_mem.w && m_mem.rd != 0 && m_mem.rd == r) return 2'b01;
      if (m_wb.v && m_wb.w && m_wb.rd != 0 && m_wb.rd == r) return 2'b10;
      return 2'b00;
   endfunction

   task automatic test_random();
      bit   rst, frz, hz, fl, lu;
      ins_t id;
      do_reset();
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
      m_ex_left = 0;
      m_stalls  = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = ($urandom_range(0, 79) == 0);
         id.v  = ($urandom_range(0, 3) != 0);
         id.w  = ($urandom_range(0, 3) != 0);
         id.ld = ($urandom_range(0, 2) == 0);
         id.md = ($urandom_range(0, 11) == 0);
         id.rs = $urandom_range(0, 3);
         id.rt = $urandom_range(0, 3);
         id.rd = $urandom_range(0, 3);
         reset = rst;
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         set_id(id.v, id.w, id.ld, id.md, id.rs, id.rt, id.rd,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         #1;
         frz = (m_ex_left > 0);
         hz  = id.v && m_ex.v && m_ex.ld && m_ex.rd != 0 &&
               ((id_uses_rs && m_ex.rd == id.rs) || (id_uses_rt && m_ex.rd == id.rt));
         fl  = ex_branch_taken && !frz;
         lu  = hz && !fl && !frz;
         exp = {!(frz || lu), !(frz || lu), !frz, fl || lu, fl, m_fwd(m_ex.rs), m_fwd(m_ex.rt)};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL random_cycle_%0d: got %b want %b", cyc, obs, exp);
         end
`ifdef PIPE_HAZARD_STALL_CNT_EN
         checks++;
         if (longint'(stall_cycles) !== m_stalls) begin
            errors++; $display("FAIL random_stall_cnt_%0d: got %0d want %0d", cyc, stall_cycles, m_stalls);
         end
`endif
         if (rst) begin
            m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
            m_ex_left = 0;
            m_stalls  = 0;
         end else begin
            if (frz || lu) m_stalls++;
            m_wb = m_mem;
            if (frz) begin
               m_mem = bubble();
               m_ex_left--;
            end else begin
               m_mem = m_ex;
               m_ex  = (fl || lu) ? bubble() : id;
               m_ex_left = (m_ex.v && m_ex.md) ? MC - 1 : 0;
            end
         end
         tick();
      end
      reset = 1'b0;
      ex_branch_taken = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ex_branch_taken = 1'b0;
      idle();
      #1;
      test_reset();
      test_load_use();
      test_forwarding();
      test_r0();
      test_muldiv();
      test_branch_load_use();
      test_reset_mid_freeze();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
